npc_arb: RTL and testbench
==========================

NPC_ARB -- requirements
Module: npc_arb

Interface
REQ-001 Parameter NREQ, default 4, number of upstream NP-core requesters (2..8).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 up_req  input  NREQ  per-requester transfer request, level.
REQ-005 up_rwn  input  NREQ  per-requester direction: 1 = read, 0 = write.
REQ-006 up_adr  input  32*NREQ  per-requester byte start address; slice i is [32i+31:32i].
REQ-007 up_len  input  32*NREQ  per-requester length in 8-byte beats.
REQ-008 up_wdt  input  64*NREQ  per-requester write data.
REQ-009 up_gnt  output  NREQ  one-hot grant pulse.
REQ-010 up_ack  output  NREQ  per-requester beat acknowledge.
REQ-011 up_done  output  NREQ  one-cycle transfer-complete pulse.
REQ-012 up_rdt  output  64  read data, broadcast to all requesters.
REQ-013 npc_req  output  1  request to the master/DMA port.
REQ-014 npc_gnt  input  1  grant from the master/DMA port.
REQ-015 npc_rwn  output  1  direction to the master/DMA port.
REQ-016 npc_adr  output  32  start address to the master/DMA port.
REQ-017 npc_len  output  32  length to the master/DMA port.
REQ-018 npc_wdt  output  64  write data to the master/DMA port.
REQ-019 npc_rdt  input  64  read data from the master/DMA port.
REQ-020 npc_ack  input  1  beat acknowledge from the master/DMA port.

Function
REQ-021 FSM SHALL have states IDLE, ZERO, REQ and XFER.
REQ-022 IDLE, any up_req set: SHALL select one winner, register owner index and its rwn/adr/len, and advance to REQ (len != 0) or ZERO (len == 0) next cycle.
REQ-023 REQ: npc_req SHALL be 1 and npc_rwn/adr/len SHALL be driven from the registered values, held constant until npc_gnt.
REQ-024 REQ with npc_gnt = 1: up_gnt[owner] SHALL pulse combinationally that cycle, npc_req SHALL drop next cycle, and state SHALL go to XFER with beat counter = 0.
REQ-025 XFER: up_ack[owner] SHALL equal npc_ack; npc_wdt SHALL equal up_wdt slice [owner] combinationally; up_rdt SHALL equal npc_rdt in all states.
REQ-026 Each npc_ack in XFER SHALL increment a 32-bit beat counter.
REQ-027 The ack that brings the counter to the registered len SHALL pulse up_done[owner] that cycle, and state SHALL return to IDLE.
REQ-028 ZERO (len == 0): up_gnt[owner] and up_done[owner] SHALL pulse together for one cycle, no npc_req SHALL be issued, and state SHALL return to IDLE.
REQ-029 npc_ack outside XFER SHALL be ignored and SHALL NOT produce any up_ack.
REQ-030 Arbitration SHALL occur only in IDLE; the earliest re-arbitration is the cycle after up_done.
REQ-031 npc_req SHALL be held until npc_gnt, so a master/DMA port still busy completing the previous transfer is tolerated.
REQ-032 Latency from up_req (IDLE) to npc_req SHALL be 1 cycle; to up_gnt it SHALL be 1 cycle plus the master/DMA grant latency.
REQ-033 Requesters SHALL hold up_req until up_gnt; rwn/adr/len changes after selection SHALL have no effect.
REQ-034 Dropping up_req after selection SHALL NOT abort the transfer.

Reset
REQ-035 rst SHALL asynchronously force state IDLE, owner 0, beat counter 0, registered rwn/adr/len 0, and the priority pointer to requester 0.
REQ-036 During and after reset: npc_req, up_gnt, up_ack and up_done SHALL be 0, and npc_rwn/adr/len SHALL be 0.
REQ-037 Reset mid-XFER SHALL abandon the transfer without up_done; the master/DMA port is reset together with this block.

Configuration
REQ-038 Macro NPC_ARB_RR_EN defined: round-robin; the search starts at (last winner + 1) mod NREQ, and the pointer updates on each selection including ZERO.
REQ-039 Macro NPC_ARB_RR_EN undefined: fixed priority, lowest index wins, and no pointer register SHALL exist.

Verification
REQ-040 up_req[2] only, rwn = 1, adr = 0x1000, len = 3, npc_gnt 1 cycle after npc_req, 3 npc_acks -> npc_adr = 0x1000 and npc_len = 3; up_gnt[2] once; up_ack[2] ×3; up_done[2] on the 3rd ack.
REQ-041 RR build, up_req = 4'b1111 held, len = 1 each -> grant order 0,1,2,3,0.
REQ-042 Fixed-priority build, same stimulus -> always requester 0.
REQ-043 Write, len = 300, npc_wdt checked against up_wdt[1] -> 300 acks, done on ack 300, counter never wraps.
REQ-044 len = 0 on requester 3 -> up_gnt[3] and up_done[3] in the same cycle; npc_req stays 0.
REQ-045 rst asserted after 2 of 5 acks -> all outputs 0 immediately and no up_done; a new request after reset is served normally.
REQ-046 npc_gnt delayed 2 cycles after npc_req -> npc_req and npc_adr/len held stable for those 2 cycles.
REQ-047 npc_ack pulsed while IDLE -> no up_ack.

Source files
------------

// File: rtl/npc_arb.sv
`default_nettype none
// ============================================================================
// Module   : npc_arb
// Purpose  : Arbitrates NREQ upstream NP-core requesters onto one master/DMA
//            port and tracks each transfer's beats to completion.
//            Define NPC_ARB_RR_EN for round-robin; otherwise fixed priority.
// Revision : 1.0
// ============================================================================
module npc_arb #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      up_req,
    input  logic [NREQ-1:0]      up_rwn,
    input  logic [32*NREQ-1:0]   up_adr,
    input  logic [32*NREQ-1:0]   up_len,
    input  logic [64*NREQ-1:0]   up_wdt,
    output logic [NREQ-1:0]      up_gnt,
    output logic [NREQ-1:0]      up_ack,
    output logic [NREQ-1:0]      up_done,
    output logic [63:0]          up_rdt,
    output logic                 npc_req,
    input  logic                 npc_gnt,
    output logic                 npc_rwn,
    output logic [31:0]          npc_adr,
    output logic [31:0]          npc_len,
    output logic [63:0]          npc_wdt,
    input  logic [63:0]          npc_rdt,
    input  logic                 npc_ack
);

    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_REQ  = 2'd2,
        S_XFER = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            rwn_q, rwn_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [IW-1:0]   win;
    logic            sel_rwn;
    logic [31:0]     sel_adr;
    logic [31:0]     sel_len;
    logic [NREQ-1:0] owner_oh;
    logic [31:0]     cnt_inc;

`ifdef NPC_ARB_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;

    // Search begins at the requester after the previous winner.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && up_req[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && |up_req)
            ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (up_req[i]) win = IW'(i);
    end
`endif

    always_comb begin
        sel_rwn = 1'b0;
        sel_adr = '0;
        sel_len = '0;
        npc_wdt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_rwn = up_rwn[i];
                sel_adr = up_adr[32*i +: 32];
                sel_len = up_len[32*i +: 32];
            end
            if (owner_q == IW'(i))
                npc_wdt = up_wdt[64*i +: 64];
        end
    end

    assign owner_oh = NREQ'(1) << owner_q;
    assign cnt_inc  = cnt_q + 32'd1;
    assign up_rdt   = npc_rdt;
    assign npc_rwn  = rwn_q;
    assign npc_adr  = adr_q;
    assign npc_len  = len_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rwn_d   = rwn_q;
        adr_d   = adr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        npc_req = 1'b0;
        up_gnt  = '0;
        up_ack  = '0;
        up_done = '0;
        case (state_q)
            S_IDLE: begin
                if (|up_req) begin
                    owner_d = win;
                    rwn_d   = sel_rwn;
                    adr_d   = sel_adr;
                    len_d   = sel_len;
                    cnt_d   = '0;
                    state_d = (sel_len == 32'd0) ? S_ZERO : S_REQ;
                end
            end
            S_ZERO: begin
                up_gnt  = owner_oh;
                up_done = owner_oh;
                state_d = S_IDLE;
            end
            S_REQ: begin
                npc_req = 1'b1;
                if (npc_gnt) begin
                    up_gnt  = owner_oh;
                    cnt_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (npc_ack) begin
                    up_ack = owner_oh;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        up_done = owner_oh;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rwn_q   <= 1'b0;
            adr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rwn_q   <= rwn_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_arb
// Purpose  : Directed self-checking bench for npc_arb (NREQ = 4).
// Revision : 1.0
// ============================================================================
module tb_npc_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   up_req, up_rwn;
    logic [127:0] up_adr, up_len;
    logic [255:0] up_wdt;
    logic [3:0]   up_gnt, up_ack, up_done;
    logic [63:0]  up_rdt;
    logic         npc_req, npc_gnt, npc_rwn, npc_ack;
    logic [31:0]  npc_adr, npc_len;
    logic [63:0]  npc_wdt, npc_rdt;

    int n_vec = 0;
    int n_err = 0;

    npc_arb #(.NREQ(4)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .up_rwn(up_rwn), .up_adr(up_adr), .up_len(up_len),
        .up_wdt(up_wdt), .up_gnt(up_gnt), .up_ack(up_ack), .up_done(up_done),
        .up_rdt(up_rdt), .npc_req(npc_req), .npc_gnt(npc_gnt),
        .npc_rwn(npc_rwn), .npc_adr(npc_adr), .npc_len(npc_len),
        .npc_wdt(npc_wdt), .npc_rdt(npc_rdt), .npc_ack(npc_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acks;
        int          cyc;
        logic        ack;
        logic [3:0]  f_exp;

        rst = 1'b1; up_req = '0; up_rwn = '0; up_adr = '0; up_len = '0; up_wdt = '0;
        npc_gnt = 1'b0; npc_ack = 1'b0; npc_rdt = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_npc_req", npc_req, 0);
        chk("rst_up_gnt",  up_gnt,  0);
        chk("rst_up_ack",  up_ack,  0);
        chk("rst_up_done", up_done, 0);
        chk("rst_npc_adr", npc_adr, 0);
        chk("rst_npc_len", npc_len, 0);
        chk("rst_npc_rwn", npc_rwn, 0);
        @(negedge clk); rst = 1'b0;

        // Single read on requester 2, len 3
        @(negedge clk);
        up_req = 4'b0100; up_rwn[2] = 1'b1; up_adr[64 +: 32] = 32'h1000; up_len[64 +: 32] = 32'd3;
        #1 chk("a_idle_npc_req", npc_req, 0);
        @(negedge clk); #1;
        chk("a_npc_req", npc_req, 1);
        chk("a_npc_adr", npc_adr, 32'h1000);
        chk("a_npc_len", npc_len, 3);
        chk("a_npc_rwn", npc_rwn, 1);
        chk("a_gnt_pre", up_gnt, 0);
        npc_gnt = 1'b1;
        #1 chk("a_up_gnt", up_gnt, 4'b0100);
        up_req = '0;
        @(negedge clk); npc_gnt = 1'b0;
        #1;
        chk("a_npc_req_drop", npc_req, 0);
        chk("a_gnt_once", up_gnt, 0);
        for (int k = 0; k < 3; k++) begin
            npc_ack = 1'b1; npc_rdt = 64'hD000 + 64'(k);
            #1;
            chk("a_up_ack", up_ack, 4'b0100);
            chk("a_up_rdt", up_rdt, 64'hD000 + 64'(k));
            chk("a_up_done", up_done, (k == 2) ? 4'b0100 : 4'b0000);
            @(negedge clk);
        end

        // Stray ack while idle
        #1;
        chk("b_idle_ack", up_ack, 0);
        chk("b_idle_done", up_done, 0);
        npc_ack = 1'b0;

        // Write on requester 1 with master grant delayed two cycles
        up_req = 4'b0010; up_rwn[1] = 1'b0; up_adr[32 +: 32] = 32'h2000; up_len[32 +: 32] = 32'd1;
        up_wdt[64 +: 64] = 64'h1111_2222_3333_4444;
        @(negedge clk); #1;
        chk("c_npc_req0", npc_req, 1);
        chk("c_npc_adr0", npc_adr, 32'h2000);
        @(negedge clk); #1;
        chk("c_npc_req1", npc_req, 1);
        chk("c_npc_adr1", npc_adr, 32'h2000);
        chk("c_npc_len1", npc_len, 1);
        chk("c_gnt_wait", up_gnt, 0);
        @(negedge clk); #1;
        chk("c_npc_req2", npc_req, 1);
        chk("c_npc_adr2", npc_adr, 32'h2000);
        npc_gnt = 1'b1;
        #1 chk("c_up_gnt", up_gnt, 4'b0010);
        up_req = '0;
        @(negedge clk); npc_gnt = 1'b0; npc_ack = 1'b1;
        #1;
        chk("c_npc_wdt", npc_wdt, 64'h1111_2222_3333_4444);
        chk("c_up_ack", up_ack, 4'b0010);
        chk("c_up_done", up_done, 4'b0010);
        @(negedge clk); npc_ack = 1'b0;
        #1 chk("c_after_done", up_done, 0);

        // Long write, len 300, with ack gaps
        up_req = 4'b0010; up_len[32 +: 32] = 32'd300; up_adr[32 +: 32] = 32'h3000;
        @(negedge clk); #1;
        chk("d_npc_len", npc_len, 300);
        chk("d_npc_rwn", npc_rwn, 0);
        npc_gnt = 1'b1;
        #1 chk("d_up_gnt", up_gnt, 4'b0010);
        up_req = '0;
        acks = 0; cyc = 0;
        while (acks < 300 && cyc < 400) begin
            @(negedge clk);
            npc_gnt = 1'b0;
            cyc++;
            ack = (cyc % 7) != 3;
            npc_ack = ack;
            up_wdt[64 +: 64] = {32'hA5A5_0000, 32'(cyc)};
            if (ack) acks++;
            #1;
            chk("d_npc_wdt", npc_wdt, {32'hA5A5_0000, 32'(cyc)});
            chk("d_up_ack", up_ack, ack ? 4'b0010 : 4'b0000);
            chk("d_up_done", up_done, (ack && acks == 300) ? 4'b0010 : 4'b0000);
        end
        chk("d_ack_count", acks, 300);
        @(negedge clk); npc_ack = 1'b0;
        #1;
        chk("d_idle_ack", up_ack, 0);
        chk("d_idle_req", npc_req, 0);

        // Zero-length on requester 3
        up_req = 4'b1000; up_len[96 +: 32] = 32'd0; up_adr[96 +: 32] = 32'h4000;
        #1 chk("e_idle_req", npc_req, 0);
        @(negedge clk); #1;
        chk("e_up_gnt", up_gnt, 4'b1000);
        chk("e_up_done", up_done, 4'b1000);
        chk("e_npc_req", npc_req, 0);
        up_req = '0;
        @(negedge clk); #1;
        chk("e_gnt_after", up_gnt, 0);
        chk("e_done_after", up_done, 0);
        chk("e_npc_req_after", npc_req, 0);

        // All four requesting, len 1 each
        up_len = {32'd1, 32'd1, 32'd1, 32'd1};
        up_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
`ifdef NPC_ARB_RR_EN
            f_exp = 4'b0001 << (t % 4);
`else
            f_exp = 4'b0001;
`endif
            @(negedge clk); npc_gnt = 1'b1;
            #1 chk("f_up_gnt", up_gnt, f_exp);
            @(negedge clk); npc_gnt = 1'b0; npc_ack = 1'b1;
            #1 chk("f_up_done", up_done, f_exp);
            @(negedge clk); npc_ack = 1'b0;
            #1 chk("f_idle_gnt", up_gnt, 0);
        end
        up_req = '0;

        // Reset in the middle of a 5-beat transfer
        @(negedge clk);
        up_req = 4'b0001; up_len[0 +: 32] = 32'd5; up_adr[0 +: 32] = 32'h5000;
        @(negedge clk); npc_gnt = 1'b1;
        #1 chk("g_up_gnt", up_gnt, 4'b0001);
        up_req = '0;
        @(negedge clk); npc_gnt = 1'b0; npc_ack = 1'b1;
        #1 chk("g_ack1", up_ack, 4'b0001);
        @(negedge clk);
        #1 chk("g_ack2", up_ack, 4'b0001);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("g_rst_ack", up_ack, 0);
        chk("g_rst_done", up_done, 0);
        chk("g_rst_req", npc_req, 0);
        chk("g_rst_adr", npc_adr, 0);
        chk("g_rst_len", npc_len, 0);
        chk("g_rst_rwn", npc_rwn, 0);
        @(negedge clk);
        npc_ack = 1'b0; rst = 1'b0;
        up_req = 4'b0101;
        up_adr[0 +: 32] = 32'h6000; up_len[0 +: 32] = 32'd1;
        up_adr[64 +: 32] = 32'h7000; up_len[64 +: 32] = 32'd1;
        @(negedge clk); #1;
        chk("h_npc_adr", npc_adr, 32'h6000);
        npc_gnt = 1'b1;
        #1 chk("h_up_gnt", up_gnt, 4'b0001);
        up_req = '0;
        @(negedge clk); npc_gnt = 1'b0; npc_ack = 1'b1; npc_rdt = 64'hCAFE;
        #1;
        chk("h_up_done", up_done, 4'b0001);
        chk("h_up_rdt", up_rdt, 64'hCAFE);
        @(negedge clk); npc_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
